// File: rtl/rf_seq_pkg.sv
// rf_seq_pkg: shared types and constants for the register-file sequencer.
package rf_seq_pkg;
   localparam int DATA_W     = 4;
   localparam int REG_ADDR_W = 2;
   localparam int OP_MSB  = 7;
   localparam int OP_LSB  = 6;
   localparam int RD_MSB  = 5;
   localparam int RD_LSB  = 4;
   localparam int RS1_MSB = 3;
   localparam int RS1_LSB = 2;
   localparam int RS2_MSB = 1;
   localparam int RS2_LSB = 0;
   localparam int IMM_MSB = 3;
   localparam int IMM_LSB = 0;
   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_LDI = 2'b11
   } op_e;
   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_WRITEBACK,
      S_HALT
   } state_e;
endpackage

// File: rtl/rf_seq_alu.sv
// rf_seq_alu: 4-bit combinational ALU producing result, zero and carry/borrow.
module rf_seq_alu
   import rf_seq_pkg::*;
(
   input  op_e               op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] imm,
   output logic [DATA_W-1:0] result,
   output logic              z,
   output logic              c
);
   logic [DATA_W:0] sum;
   assign sum = {1'b0, a} + {1'b0, b};
   always_comb begin
      result = imm;
      c      = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum[DATA_W-1:0];
            c      = sum[DATA_W];
         end
         OP_SUB: begin
            result = a - b;
            c      = a < b;
         end
         OP_AND: result = a & b;
         default: result = imm;
      endcase
   end
   assign z = result == '0;
endmodule

// File: rtl/rf_sequencer.sv
// rf_sequencer: multi-cycle fetch/decode/execute/writeback master for the 4x4 register file.
module rf_sequencer
   import rf_seq_pkg::*;
#(
   parameter int PC_W     = 4,
   parameter int PROG_LEN = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic [PC_W-1:0]       imem_addr,
   input  logic [7:0]            imem_data,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_rs1_addr,
   output logic [REG_ADDR_W-1:0] rf_rs2_addr,
   output logic [REG_ADDR_W-1:0] rf_rd_addr,
   output logic [DATA_W-1:0]     rf_rd_data,
   input  logic [DATA_W-1:0]     rf_rs1_data,
   input  logic [DATA_W-1:0]     rf_rs2_data,
   output logic                  busy,
   output logic                  halted,
   output logic                  flag_z,
   output logic                  flag_c
);
   localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);
   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [7:0]        ir_q, ir_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              zp_q, zp_d, cp_q, cp_d;
   logic              fz_q, fz_d, fc_q, fc_d;
   logic [DATA_W-1:0] alu_res;
   logic              alu_z, alu_c;
   rf_seq_alu u_alu (
      .op     (op_e'(ir_q[OP_MSB:OP_LSB])),
      .a      (rf_rs1_data),
      .b      (rf_rs2_data),
      .imm    (ir_q[IMM_MSB:IMM_LSB]),
      .result (alu_res),
      .z      (alu_z),
      .c      (alu_c)
   );
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         res_q   <= '0;
         zp_q    <= 1'b0;
         cp_q    <= 1'b0;
         fz_q    <= 1'b0;
         fc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         res_q   <= res_d;
         zp_q    <= zp_d;
         cp_q    <= cp_d;
         fz_q    <= fz_d;
         fc_q    <= fc_d;
      end
   end
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      res_d   = res_q;
      zp_d    = zp_q;
      cp_d    = cp_q;
      fz_d    = fz_q;
      fc_d    = fc_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
               pc_d    = '0;
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            ir_d    = imem_data;
            state_d = S_EXECUTE;
         end
         S_EXECUTE: begin
            res_d   = alu_res;
            zp_d    = alu_z;
            cp_d    = alu_c;
            state_d = S_WRITEBACK;
         end
         S_WRITEBACK: begin
            fz_d = zp_q;
            fc_d = cp_q;
            // Halting on the last pc keeps the counter from ever wrapping.
            if (pc_q == LAST_PC) begin
               state_d = S_HALT;
            end else begin
               pc_d    = pc_q + PC_W'(1);
               state_d = S_FETCH;
            end
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end
   assign imem_addr   = pc_q;
   assign rf_we       = state_q == S_WRITEBACK;
   assign rf_rs1_addr = ir_q[RS1_MSB:RS1_LSB];
   assign rf_rs2_addr = ir_q[RS2_MSB:RS2_LSB];
   assign rf_rd_addr  = ir_q[RD_MSB:RD_LSB];
   assign rf_rd_data  = res_q;
   assign busy        = state_q inside {S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK};
   assign halted      = state_q == S_HALT;
   assign flag_z      = fz_q;
   assign flag_c      = fc_q;
endmodule

// File: tb/tb_rf_sequencer.sv
// tb_rf_sequencer: scoreboard bench driving 3-instruction programs through rf_sequencer.
module tb_rf_sequencer;
   localparam int PC_W     = 4;
   localparam int PROG_LEN = 3;
   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic [PC_W-1:0] imem_addr;
   logic [7:0]      imem_data;
   logic            rf_we;
   logic [1:0]      rf_rs1_addr, rf_rs2_addr, rf_rd_addr;
   logic [3:0]      rf_rd_data, rf_rs1_data, rf_rs2_data;
   logic            busy, halted, flag_z, flag_c;
   always #5 clk = ~clk;
   rf_sequencer #(.PC_W(PC_W), .PROG_LEN(PROG_LEN)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .rf_we       (rf_we),
      .rf_rs1_addr (rf_rs1_addr),
      .rf_rs2_addr (rf_rs2_addr),
      .rf_rd_addr  (rf_rd_addr),
      .rf_rd_data  (rf_rd_data),
      .rf_rs1_data (rf_rs1_data),
      .rf_rs2_data (rf_rs2_data),
      .busy        (busy),
      .halted      (halted),
      .flag_z      (flag_z),
      .flag_c      (flag_c)
   );
   logic [7:0] rom [16];
   logic [3:0] regs [4];
   always @(posedge clk) imem_data <= rom[imem_addr];
   always @(posedge clk) if (rf_we) regs[rf_rd_addr] <= rf_rd_data;
   assign rf_rs1_data = regs[rf_rs1_addr];
   assign rf_rs2_data = regs[rf_rs2_addr];
   typedef struct {
      int         cyc;
      logic [1:0] rd;
      logic [3:0] d;
      logic       z;
      logic       c;
   } exp_t;
   exp_t       exp_q[$];
   logic [3:0] m [4];
   int         total = 0;
   int         bad = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic logic [7:0] ins(input logic [1:0] op, input logic [1:0] rd, input logic [3:0] lo);
      return {op, rd, lo};
   endfunction
   task automatic load(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
      foreach (rom[i]) rom[i] = 8'h00;
      rom[0] = p0;
      rom[1] = p1;
      rom[2] = p2;
   endtask
   task automatic push_model();
      logic [7:0] w;
      logic [3:0] a, b, r;
      logic [4:0] s;
      logic       c;
      for (int i = 0; i < PROG_LEN; i++) begin
         w = rom[i];
         a = m[w[3:2]];
         b = m[w[1:0]];
         c = 1'b0;
         case (w[7:6])
            2'b00: begin
               s = {1'b0, a} + {1'b0, b};
               r = s[3:0];
               c = s[4];
            end
            2'b01: begin
               r = a - b;
               c = a < b;
            end
            2'b10: r = a & b;
            default: r = w[3:0];
         endcase
         m[w[5:4]] = r;
         exp_q.push_back('{cyc: 4 * (i + 1), rd: w[5:4], d: r, z: (r == 4'd0), c: c});
      end
   endtask
   task automatic run(input int busy_start, input int rst_at);
      int   writes = 0;
      int   fl_cyc = -1;
      logic ez = 1'b0, ec = 1'b0;
      exp_t e;
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      chk("idle_busy", 32'(busy), 0);
      chk("idle_halted", 32'(halted), 0);
      chk("idle_we", 32'(rf_we), 0);
      chk("idle_addr", 32'(imem_addr), 0);
      exp_q.delete();
      push_model();
      start = 1'b1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         start = (cyc == busy_start);
         if (cyc == rst_at) begin
            reset = 1'b1;
            #1;
            chk("rst_we", 32'(rf_we), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_halted", 32'(halted), 0);
            chk("rst_addr", 32'(imem_addr), 0);
            chk("rst_rs", 32'({rf_rs1_addr, rf_rs2_addr, rf_rd_addr}), 0);
            chk("rst_data", 32'(rf_rd_data), 0);
            chk("rst_flags", 32'({flag_z, flag_c}), 0);
            exp_q.delete();
            fl_cyc = -1;
            @(negedge clk) reset = 1'b0;
         end
         if (rst_at < 0 && (cyc == 1 || cyc == 5 || cyc == 9))
            chk("fetch_pc", 32'(imem_addr), (cyc - 1) / 4);
         if (cyc == fl_cyc) begin
            chk("flag_z", 32'(flag_z), 32'(ez));
            chk("flag_c", 32'(flag_c), 32'(ec));
         end
         if (rf_we) begin
            writes++;
            if (exp_q.size() == 0) begin
               chk("spurious_we", 32'(rf_we), 0);
            end else begin
               e = exp_q.pop_front();
               chk("we_cycle", cyc, e.cyc);
               chk("rd_addr", 32'(rf_rd_addr), 32'(e.rd));
               chk("rd_data", 32'(rf_rd_data), 32'(e.d));
               fl_cyc = cyc + 1;
               ez = e.z;
               ec = e.c;
            end
         end
      end
      if (rst_at < 0) begin
         chk("writes", writes, PROG_LEN);
         chk("halted", 32'(halted), 1);
         chk("halt_busy", 32'(busy), 0);
         chk("leftover", exp_q.size(), 0);
         @(negedge clk) start = 1'b1;
         @(negedge clk) start = 1'b0;
         repeat (4) begin
            @(negedge clk);
            chk("halt_we", 32'(rf_we), 0);
            chk("halt_addr", 32'(imem_addr), PROG_LEN - 1);
         end
      end else begin
         chk("rst_writes", writes, 1);
         chk("rst_idle_busy", 32'(busy), 0);
         chk("rst_idle_halted", 32'(halted), 0);
      end
   endtask
   initial begin
      foreach (m[i]) m[i] = 4'd0;
      repeat (2) @(negedge clk);
      load(ins(2'b11, 2'd0, 4'd5), ins(2'b11, 2'd1, 4'd9), ins(2'b00, 2'd2, 4'b0001));
      run(5, -1);
      load(ins(2'b11, 2'd0, 4'd9), ins(2'b11, 2'd1, 4'd9), ins(2'b00, 2'd3, 4'b0001));
      run(-1, -1);
      load(ins(2'b11, 2'd0, 4'd9), ins(2'b11, 2'd1, 4'd9), ins(2'b01, 2'd3, 4'b0001));
      run(-1, -1);
      load(ins(2'b11, 2'd0, 4'd3), ins(2'b11, 2'd1, 4'd5), ins(2'b01, 2'd2, 4'b0001));
      run(-1, -1);
      load(ins(2'b11, 2'd0, 4'd3), ins(2'b11, 2'd1, 4'd5), ins(2'b10, 2'd2, 4'b0101));
      run(-1, -1);
      load(ins(2'b11, 2'd0, 4'd5), ins(2'b11, 2'd1, 4'd9), ins(2'b00, 2'd2, 4'b0001));
      run(-1, 7);
      run(-1, -1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
